// File: rtl/ff_apb_master_pkg.sv
// Shared definitions for the APB4 master: FSM state encoding, width helpers
// and the level driven on every bus output while no transfer is in flight.
package ff_apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic BUS_IDLE = 1'b0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >>> 1) r++;
      return r;
   endfunction

   // Vector width able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/ff_apb_master_if.sv
// Command/response side and APB fabric side of the master, bundled together.
// The master modport is the view of ff_apb_master; slave is the environment's view.
interface ff_apb_master_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int NSLV   = 4
) ();

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [ADDR_W-1:0]        cmd_addr;
   logic [DATA_W-1:0]        cmd_wdata;
   logic [DATA_W/8-1:0]      cmd_strb;

   logic                     rsp_valid;
   logic [DATA_W-1:0]        rsp_rdata;
   logic                     rsp_err;
   logic                     rsp_timeout;

   logic [ADDR_W-1:0]        paddr;
   logic                     pwrite;
   logic [NSLV-1:0]          psel;
   logic                     penable;
   logic [DATA_W-1:0]        pwdata;
   logic [DATA_W/8-1:0]      pstrb;
   logic [NSLV*DATA_W-1:0]   prdata;
   logic [NSLV-1:0]          pready;
   logic [NSLV-1:0]          pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output paddr, pwrite, psel, penable, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  paddr, pwrite, psel, penable, pwdata, pstrb,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/ff_apb_slv_mux.sv
// Picks pready, pslverr and the prdata slice of the addressed slave; the
// other slaves' return signals never reach the master's control logic.
module ff_apb_slv_mux
   import ff_apb_master_pkg::*;
#(
   parameter int NSLV   = 4,
   parameter int DATA_W = 32
) (
   input  logic [idx_width(NSLV)-1:0] idx,
   input  logic [NSLV*DATA_W-1:0]     prdata,
   input  logic [NSLV-1:0]            pready,
   input  logic [NSLV-1:0]            pslverr,
   output logic                       sel_ready,
   output logic                       sel_err,
   output logic [DATA_W-1:0]          sel_rdata
);

   localparam int IDX_W = idx_width(NSLV);

   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; without that, synthesis infers a latch.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/ff_apb_master.sv
// APB4 master: converts single commands into SETUP/ACCESS transfers with
// wait states, slave errors, address-decode errors and an access timeout.
module ff_apb_master
   import ff_apb_master_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int NSLV    = 4,
   parameter int SLV_AW  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic            pclk,
   input  logic            presetn,
   ff_apb_master_if.master bus
);

   localparam int IDX_W  = idx_width(NSLV);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = idx_width(TIMEOUT + 1);

   apb_state_e           state_q, state_d;

   logic                 write_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [STRB_W-1:0]    strb_q;
   logic [IDX_W-1:0]     idx_q;
   logic [CNT_W-1:0]     cnt_q;

   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    rsp_rdata_q;
   logic                 rsp_err_q;
   logic                 rsp_timeout_q;

   logic                 accept, dec_err, done, tmo;
   logic                 sel_ready, sel_err;
   logic [DATA_W-1:0]    sel_rdata;

   // The window number uses every address bit above the slave window, so
   // addresses beyond the last slave decode as an error instead of aliasing.
   logic [ADDR_W-1:0]    cmd_slv;
   logic                 cmd_in_range;

   assign cmd_slv      = bus.cmd_addr >> SLV_AW;
   assign cmd_in_range = (cmd_slv < ADDR_W'(NSLV));

   ff_apb_slv_mux #(
      .NSLV   (NSLV),
      .DATA_W (DATA_W)
   ) u_slv_mux (
      .idx       (idx_q),
      .prdata    (bus.prdata),
      .pready    (bus.pready),
      .pslverr   (bus.pslverr),
      .sel_ready (sel_ready),
      .sel_err   (sel_err),
      .sel_rdata (sel_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      dec_err = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               accept = 1'b1;
               if (cmd_in_range) state_d = ST_SETUP;
               else              dec_err = 1'b1;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (sel_ready) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else if ((TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1)) begin
               tmo     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs come straight from state and latched command, so they
   // return to idle the moment reset asserts.
   always_comb begin
      bus.cmd_ready = (state_q == ST_IDLE);
      bus.penable   = (state_q == ST_ACCESS);
      bus.paddr     = {ADDR_W{BUS_IDLE}};
      bus.pwrite    = BUS_IDLE;
      bus.pwdata    = {DATA_W{BUS_IDLE}};
      bus.pstrb     = {STRB_W{BUS_IDLE}};
      bus.psel      = {NSLV{BUS_IDLE}};
      if (state_q != ST_IDLE) begin
         bus.paddr  = addr_q;
         bus.pwrite = write_q;
         bus.pwdata = wdata_q;
         bus.pstrb  = strb_q;
         for (int i = 0; i < NSLV; i++) bus.psel[i] = (idx_q == IDX_W'(i));
      end
   end

   // Read commands latch zero data/strobes so the bus shows 0 on reads.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         idx_q   <= '0;
      end else if (accept) begin
         write_q <= bus.cmd_write;
         addr_q  <= bus.cmd_addr;
         wdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
         strb_q  <= bus.cmd_write ? bus.cmd_strb  : '0;
         idx_q   <= cmd_slv[IDX_W-1:0];
      end
   end

   // Saturating so that TIMEOUT = 0 (no abort) cannot wrap back to zero.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else if (state_d == ST_SETUP) begin
         cnt_q <= '0;
      end else if ((state_q == ST_ACCESS) && !sel_ready && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         rsp_valid_q <= done | tmo | dec_err;
         if (done) begin
            rsp_rdata_q   <= (!write_q && !sel_err) ? sel_rdata : '0;
            rsp_err_q     <= sel_err;
            rsp_timeout_q <= 1'b0;
         end else if (tmo) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
         end else if (dec_err) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ff_apb_master.sv
// Self-checking bench for ff_apb_master: directed scenarios plus randomized
// commands scored against a transaction-level model of the APB master.
module tb_ff_apb_master;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int NSLV    = 4;
   localparam int SLV_AW  = 12;
   localparam int TIMEOUT = 8;

   logic pclk    = 1'b0;
   logic presetn = 1'b0;

   always #5 pclk = ~pclk;

   ff_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();

   ff_apb_master #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .NSLV    (NSLV),
      .SLV_AW  (SLV_AW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus snapshot: {psel, penable, pwrite, paddr, pwdata, pstrb}.
   function automatic logic [63:0] obs_bus();
      return {6'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb};
   endfunction

   function automatic logic [63:0] pack_bus(input logic [3:0] sel, input logic en, input logic wr,
                                            input logic [15:0] a, input logic [31:0] d,
                                            input logic [3:0] s);
      return {6'd0, sel, en, wr, a, d, s};
   endfunction

   // Response snapshot: {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}.
   function automatic logic [63:0] obs_rsp();
      return {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
   endfunction

   function automatic logic [63:0] pack_rsp(input logic v, input logic e, input logic t,
                                            input logic [31:0] d);
      return {29'd0, v, e, t, d};
   endfunction

   typedef struct {
      bit          dec;
      int          idx;
      int          n_access;
      logic        err;
      logic        tmo;
      logic [31:0] rdata;
   } exp_t;

   // Transaction-level expectation from the protocol rules alone.
   function automatic exp_t model(input logic wr, input logic [15:0] addr, input int waits,
                                  input logic serr, input logic [31:0] rd);
      exp_t m;
      m.idx      = int'(addr) / (1 << SLV_AW);
      m.dec      = (m.idx >= NSLV);
      m.n_access = 0;
      m.err      = 1'b1;
      m.tmo      = 1'b0;
      m.rdata    = '0;
      if (!m.dec) begin
         if (waits >= TIMEOUT) begin
            m.n_access = TIMEOUT;
            m.tmo      = 1'b1;
         end else begin
            m.n_access = waits + 1;
            m.err      = serr;
            m.rdata    = (wr || serr) ? 32'd0 : rd;
         end
      end
      return m;
   endfunction

   // sel < 0 randomizes every slave; otherwise slave sel gets fixed values.
   task automatic drive_slaves(input int sel, input logic rdy, input logic err, input logic [31:0] rd);
      for (int i = 0; i < NSLV; i++) begin
         if (i == sel) begin
            bus.pready[i]                  = rdy;
            bus.pslverr[i]                 = err;
            bus.prdata[i*DATA_W +: DATA_W] = rd;
         end else begin
            bus.pready[i]                  = 1'($urandom);
            bus.pslverr[i]                 = 1'($urandom);
            bus.prdata[i*DATA_W +: DATA_W] = $urandom;
         end
      end
   endtask

   task automatic scramble_cmd();
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 16'($urandom);
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = 4'($urandom);
   endtask

   // Runs one command from an idle negedge and checks every cycle up to the
   // cycle after its response.
   task automatic run_cmd(input string name, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wd, input logic [3:0] st, input int waits,
                          input logic serr, input logic [31:0] rd);
      exp_t        m;
      logic [63:0] word;
      m = model(wr, addr, waits, serr, rd);
      check($sformatf("%s.ready", name), 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_strb  = st;
      drive_slaves(-1, 1'b0, 1'b0, '0);
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      scramble_cmd();
      if (!m.dec) begin
         word = pack_bus(4'(1 << m.idx), 1'b0, wr, addr, wr ? wd : 32'd0, wr ? st : 4'd0);
         check($sformatf("%s.setup", name), obs_bus(), word);
         check($sformatf("%s.busy", name), 64'({bus.cmd_ready, bus.rsp_valid}), 64'd0);
         drive_slaves(-1, 1'b0, 1'b0, '0);
         word = pack_bus(4'(1 << m.idx), 1'b1, wr, addr, wr ? wd : 32'd0, wr ? st : 4'd0);
         for (int k = 0; k < m.n_access; k++) begin
            @(negedge pclk);
            check($sformatf("%s.access%0d", name, k), obs_bus(), word);
            check($sformatf("%s.abusy%0d", name, k), 64'({bus.cmd_ready, bus.rsp_valid}), 64'd0);
            drive_slaves(m.idx, (k >= waits) ? 1'b1 : 1'b0, serr, rd);
         end
         @(negedge pclk);
      end
      check($sformatf("%s.rsp", name), obs_rsp(), pack_rsp(1'b1, m.err, m.tmo, m.rdata));
      check($sformatf("%s.idle", name), obs_bus(), 64'd0);
      check($sformatf("%s.rdy_rsp", name), 64'(bus.cmd_ready), 64'd1);
      drive_slaves(-1, 1'b0, 1'b0, '0);
      @(negedge pclk);
      check($sformatf("%s.hold", name), obs_rsp(), pack_rsp(1'b0, m.err, m.tmo, m.rdata));
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      drive_slaves(-1, 1'b0, 1'b0, '0);

      repeat (2) @(negedge pclk);
      check("reset.bus", obs_bus(), 64'd0);
      check("reset.rsp", obs_rsp(), 64'd0);
      check("reset.ready", 64'(bus.cmd_ready), 64'd1);
      presetn = 1'b1;
      @(negedge pclk);

      run_cmd("t1_wr",  1'b1, 16'h1010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
      run_cmd("t2_rd",  1'b0, 16'h2004, 32'hA5A5A5A5, 4'hF, 5, 1'b0, 32'h12345678);
      run_cmd("t3_err", 1'b0, 16'h3000, 32'h0,        4'h0, 0, 1'b1, 32'hCAFEF00D);
      run_cmd("t4_tmo", 1'b0, 16'h0040, 32'h0,        4'h0, 1000, 1'b0, 32'h11112222);
      run_cmd("t4_next",1'b1, 16'h0044, 32'h01020304, 4'h3, 2, 1'b0, 32'h0);
      run_cmd("dec",    1'b1, 16'h8010, 32'h55555555, 4'hF, 0, 1'b0, 32'h0);
      run_cmd("t_rd7",  1'b0, 16'h1FFC, 32'h0,        4'h0, 7, 1'b0, 32'h0BADC0DE);

      // Back-to-back: cmd_valid stays high, second write accepted in the
      // first response's cycle.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 16'h0100;
      bus.cmd_wdata = 32'h0000AAAA;
      bus.cmd_strb  = 4'h1;
      drive_slaves(-1, 1'b0, 1'b0, '0);
      @(negedge pclk);
      check("b2b.setup1", obs_bus(), pack_bus(4'b0001, 1'b0, 1'b1, 16'h0100, 32'h0000AAAA, 4'h1));
      bus.cmd_addr  = 16'h1200;
      bus.cmd_wdata = 32'hBBBB0000;
      bus.cmd_strb  = 4'hC;
      @(negedge pclk);
      check("b2b.access1", obs_bus(), pack_bus(4'b0001, 1'b1, 1'b1, 16'h0100, 32'h0000AAAA, 4'h1));
      drive_slaves(0, 1'b1, 1'b0, 32'h0);
      @(negedge pclk);
      check("b2b.rsp1", obs_rsp(), pack_rsp(1'b1, 1'b0, 1'b0, 32'h0));
      check("b2b.rdy1", 64'(bus.cmd_ready), 64'd1);
      drive_slaves(-1, 1'b0, 1'b0, '0);
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      check("b2b.setup2", obs_bus(), pack_bus(4'b0010, 1'b0, 1'b1, 16'h1200, 32'hBBBB0000, 4'hC));
      check("b2b.pulse", 64'(bus.rsp_valid), 64'd0);
      @(negedge pclk);
      check("b2b.access2", obs_bus(), pack_bus(4'b0010, 1'b1, 1'b1, 16'h1200, 32'hBBBB0000, 4'hC));
      drive_slaves(1, 1'b1, 1'b0, 32'h0);
      @(negedge pclk);
      check("b2b.rsp2", obs_rsp(), pack_rsp(1'b1, 1'b0, 1'b0, 32'h0));
      @(negedge pclk);

      // Reset in the middle of an ACCESS phase.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 16'h2004;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      @(negedge pclk);
      drive_slaves(2, 1'b0, 1'b0, 32'h77777777);
      check("rst.in_access", 64'(bus.penable), 64'd1);
      #2;
      presetn = 1'b0;
      for (int i = 0; i < NSLV; i++) bus.pready[i] = 1'b1;
      #1;
      check("rst.async_bus", obs_bus(), 64'd0);
      check("rst.async_rsp", obs_rsp(), 64'd0);
      check("rst.async_rdy", 64'(bus.cmd_ready), 64'd1);
      @(negedge pclk);
      #1;
      presetn = 1'b1;
      @(negedge pclk);
      check("rst.ready_after", 64'(bus.cmd_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst.no_rsp%0d", i), obs_rsp(), 64'd0);
         check($sformatf("rst.idle%0d", i), obs_bus(), 64'd0);
         @(negedge pclk);
      end
      run_cmd("rst.after", 1'b0, 16'h3008, 32'h0, 4'h0, 1, 1'b0, 32'h87654321);

      // Randomized commands; some hit timeouts, slave errors or decode errors.
      for (int n = 0; n < 40; n++) begin
         logic [15:0] a;
         int          w;
         a = 16'($urandom_range(0, 16'h3FFF));
         if ($urandom_range(0, 7) == 0) a[15:14] = 2'($urandom_range(1, 3));
         w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 3))
                                         : int'($urandom_range(0, TIMEOUT - 1));
         run_cmd($sformatf("rnd%0d", n), 1'($urandom), a, $urandom, 4'($urandom), w,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ff_apb_master.md
Name: ff_apb_master

Overview:
Synthesizable, parametrised APB4 master that turns a simple command/response interface into APB transfers.
- Successor to the APB master BFM: same bus protocol, now usable as RTL inside the design.
- Adds PREADY wait states, PSLVERR, PSTRB, a multi-slave PSEL decode, address-decode errors and an access timeout.
- Sits between an internal initiator (debug bridge or CPU load/store path) and the peripheral APB fabric.

Parameters:
- ADDR_W, 16: paddr / cmd_addr width.
- DATA_W, 32: data width; must be a multiple of 8.
- NSLV, 4: number of slaves / psel bits; power of two, at least 1.
- SLV_AW, 12: address bits per slave window. Slave index = cmd_addr[SLV_AW +: clog2(NSLV)].
- TIMEOUT, 255: max ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- presetn  in  1  asynchronous active-low reset.
- pclk  in  1  clock; all logic on rising edge.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- rsp_timeout  out  1  error cause was timeout.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- prdata  in  NSLV*DATA_W  flattened slave read data; slave i at [i*DATA_W +: DATA_W].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

Behaviour:
- Reset, asynchronous: state IDLE, cmd_ready=1. These outputs are 0: rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, pwrite, psel, penable, pwdata, pstrb. Timeout counter is 0.
- Reset mid-transfer: bus drops to idle immediately. No response is ever issued for the aborted command.
- States are IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch write, addr, wdata and strb, then compute the slave index.
  - Index < NSLV: go to SETUP.
  - Index >= NSLV (only possible if the address space exceeds NSLV windows): decode error. Stay in IDLE with no bus activity. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP (exactly 1 cycle):
  - psel[idx]=1, penable=0.
  - paddr, pwrite and pwdata driven from the latched command.
  - pstrb = latched strobes on writes, 0 on reads. pwdata = 0 on reads.
  - Always go to ACCESS.
- ACCESS:
  - penable=1; all other bus signals held stable.
  - Completes on pready[idx]=1:
    - Capture prdata slice idx (reads only) and pslverr[idx].
    - Return to IDLE with the bus idled (all bus outputs 0).
    - Next cycle rsp_valid=1 carrying the captured data and err.
  - Timeout counter increments each ACCESS cycle with pready[idx]=0.
  - If TIMEOUT != 0 and the count reaches TIMEOUT: abort to IDLE. Response is rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- Only pready, pslverr and prdata of the selected slave are observed; unselected slaves' inputs are ignored.
- Latency: command accepted at edge N, SETUP in cycle N+1, ACCESS from N+2. With zero wait states, rsp_valid is in cycle N+3.
- cmd_ready is low during SETUP and ACCESS. It is high in the rsp_valid cycle, so a new command may be accepted in the same cycle as a response (back-to-back throughput: 1 transfer per 3 cycles).
- Responses have no backpressure; the initiator must sample rsp_valid when it is high.
- rsp_* hold their last values except rsp_valid, which is a 1-cycle pulse.

Decomposition:
- Shared header ff_apb_defs.vh holds:
  - state encodings (IDLE=0, SETUP=1, ACCESS=2);
  - the clog2 function;
  - the bus-idle constant values.
- One sub-module, ff_apb_slv_mux: combinational selection of pready, pslverr and the prdata slice by slave index, parametrised by NSLV and DATA_W.

Test Plan:
1. Write addr 0x1010, data 0xDEADBEEF, strb 0xF, slave 1 ready immediately -> psel=4'b0010. Then one SETUP cycle, one ACCESS cycle. rsp_valid at N+3 with err=0; pstrb=0xF, pwdata=0xDEADBEEF stable through ACCESS.
2. Read addr 0x2004, slave 2 holds pready low 5 cycles, prdata=0x12345678 -> 6 ACCESS cycles with bus stable; rsp_rdata=0x12345678, err=0; pstrb=0 and pwdata=0 throughout.
3. Read addr 0x3000 with pslverr[3]=1 when pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
4. TIMEOUT=8, slave 0 never ready -> exactly 8 ACCESS cycles, then bus idle. rsp_err=1, rsp_timeout=1; the next command is accepted normally.
5. cmd_valid held high with two back-to-back writes -> the second is accepted in the first response's cycle; transfers are 3 cycles apart.
6. Assert presetn=0 during ACCESS of a read -> all outputs 0 asynchronously; no rsp_valid after release; cmd_ready=1 on the first cycle after release.
